// File: rtl/sys_run_ctrl_if.sv
// Datapath-side bundle for the run/step controller.
// The controller owns clock-enable and PC-load; the datapath owns PC and exception.
interface sys_run_ctrl_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc_in;
    logic            exc_in;
    logic            cpu_en;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;

    modport master (
        input  pc_in,
        input  exc_in,
        output cpu_en,
        output pc_load,
        output pc_load_val
    );

    modport slave (
        output pc_in,
        output exc_in,
        input  cpu_en,
        input  pc_load,
        input  pc_load_val
    );
endinterface

// File: rtl/sys_run_ctrl.sv
// Run/step controller: free-run, single-step, PC load, halt, breakpoint
// and exception stop, plus a saturating committed-instruction counter.
module sys_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 8
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             SYS_run,
    input  logic             SYS_step,
    input  logic             SYS_halt,
    input  logic             SYS_load,
    input  logic [PC_W-1:0]  SYS_pc_val,
    input  logic             SYS_bp_en,
    input  logic [PC_W-1:0]  SYS_bp_addr,
    sys_run_ctrl_if.master   dp,
    output logic [2:0]       state,
    output logic             exc_flag,
    output logic [PC_W-1:0]  exc_pc,
    output logic             bp_flag,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        EXC  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [3:0]        in_q;
    logic [3:0]        req_q;
    logic [3:0]        req_in;
    logic [PC_W-1:0]   pc_val_q;
    logic              pc_load_q;
    logic [PC_W-1:0]   pc_load_val_q;
    logic              bp_armed_q;
    logic              exc_flag_q;
    logic [PC_W-1:0]   exc_pc_q;
    logic              bp_flag_q;
    logic [CNT_W-1:0]  cnt_q;

    logic halt_e, load_e, step_e, run_e;
    logic bp_hit;
    logic cpu_en_c;
    logic set_exc;
    logic set_bp;

    // Request order in the vector: {halt, load, step, run}
    assign req_in = {SYS_halt, SYS_load, SYS_step, SYS_run};
    assign halt_e = req_q[3];
    assign load_e = req_q[2];
    assign step_e = req_q[1];
    assign run_e  = req_q[0];

    assign bp_hit = (state_q == RUN) & SYS_bp_en &
                    (dp.pc_in == SYS_bp_addr) & bp_armed_q;

    always_comb begin
        state_d  = state_q;
        cpu_en_c = 1'b0;
        set_exc  = 1'b0;
        set_bp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt_e)      state_d = IDLE;
                else if (load_e) state_d = LOAD;
                else if (step_e) state_d = STEP;
                else if (run_e)  state_d = RUN;
            end
            LOAD: state_d = IDLE;
            RUN: begin
                cpu_en_c = ~dp.exc_in & ~bp_hit;
                if (dp.exc_in) begin
                    state_d = EXC;
                    set_exc = 1'b1;
                end else if (bp_hit) begin
                    state_d = IDLE;
                    set_bp  = 1'b1;
                end else if (halt_e) begin
                    state_d = IDLE;
                end else if (load_e) begin
                    state_d = LOAD;
                end
            end
            STEP: begin
                cpu_en_c = ~dp.exc_in;
                if (dp.exc_in) begin
                    state_d = EXC;
                    set_exc = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            EXC: begin
                if (halt_e)      state_d = IDLE;
                else if (load_e) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q       <= IDLE;
            in_q          <= 4'd0;
            req_q         <= 4'd0;
            pc_val_q      <= '0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            bp_armed_q    <= 1'b0;
            exc_flag_q    <= 1'b0;
            exc_pc_q      <= '0;
            bp_flag_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= req_in;
            req_q      <= req_in & ~in_q;
            if (SYS_load & ~in_q[2]) pc_val_q <= SYS_pc_val;
            pc_load_q  <= (state_d == LOAD);
            if (state_d == LOAD) pc_load_val_q <= pc_val_q;
            // Disarmed for the first RUN cycle so a run can leave the bp PC
            bp_armed_q <= (state_q == RUN);
            if (state_q == LOAD) begin
                exc_flag_q <= 1'b0;
                exc_pc_q   <= '0;
                bp_flag_q  <= 1'b0;
                cnt_q      <= '0;
            end else begin
                if (set_exc) begin
                    exc_flag_q <= 1'b1;
                    exc_pc_q   <= dp.pc_in;
                end
                if (set_bp) bp_flag_q <= 1'b1;
                else if (run_e | step_e | load_e) bp_flag_q <= 1'b0;
                if (cpu_en_c && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign dp.cpu_en      = cpu_en_c;
    assign dp.pc_load     = pc_load_q;
    assign dp.pc_load_val = pc_load_val_q;
    assign state          = state_q;
    assign exc_flag       = exc_flag_q;
    assign exc_pc         = exc_pc_q;
    assign bp_flag        = bp_flag_q;
    assign cycle_cnt      = cnt_q;

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Directed bench for sys_run_ctrl with a small PC datapath model
// (+4 per commit, load on pc_load) and a PC-matched exception source.
module tb_sys_run_ctrl;

    logic       clk;
    logic       rst;
    logic       run, step, halt, load;
    logic [7:0] pc_val;
    logic       bp_en;
    logic [7:0] bp_addr;
    logic [2:0] state;
    logic       exc_flag;
    logic [7:0] exc_pc;
    logic       bp_flag;
    logic [3:0] cycle_cnt;

    logic [7:0] pc;
    logic       exc_arm;
    logic [7:0] exc_at;

    int total;
    int bad;

    sys_run_ctrl_if #(.PC_W(8)) dp ();

    sys_run_ctrl #(.CNT_W(4), .PC_W(8)) dut (
        .SYS_clk     (clk),
        .SYS_reset   (rst),
        .SYS_run     (run),
        .SYS_step    (step),
        .SYS_halt    (halt),
        .SYS_load    (load),
        .SYS_pc_val  (pc_val),
        .SYS_bp_en   (bp_en),
        .SYS_bp_addr (bp_addr),
        .dp          (dp),
        .state       (state),
        .exc_flag    (exc_flag),
        .exc_pc      (exc_pc),
        .bp_flag     (bp_flag),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dp.pc_in  = pc;
    assign dp.exc_in = exc_arm && (pc == exc_at);

    always @(posedge clk) begin
        if (dp.pc_load) pc <= dp.pc_load_val;
        else if (dp.cpu_en) pc <= pc + 8'd4;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        pc_val = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        total++;
        if (state !== 3'd0 || dp.cpu_en !== 1'b0 || dp.pc_load !== 1'b0) begin
            bad++;
            $display("FAIL rst_ctl got st=%0d en=%b ld=%b want 0 0 0",
                     state, dp.cpu_en, dp.pc_load);
        end
        total++;
        if (dp.pc_load_val !== 8'h00 || exc_flag !== 1'b0 || exc_pc !== 8'h00
            || bp_flag !== 1'b0 || cycle_cnt !== 4'd0) begin
            bad++;
            $display("FAIL rst_out got val=%h ef=%b epc=%h bf=%b cnt=%0d want 0",
                     dp.pc_load_val, exc_flag, exc_pc, bp_flag, cycle_cnt);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_load;
        pc_val = 8'h10;
        load = 1'b1;
        tick(1);
        total++;
        if (state !== 3'd0 || dp.pc_load !== 1'b0) begin
            bad++;
            $display("FAIL load_lat got st=%0d ld=%b want 0 0", state, dp.pc_load);
        end
        load = 1'b0;
        tick(1);
        total++;
        if (state !== 3'd1 || dp.pc_load !== 1'b1 || dp.pc_load_val !== 8'h10) begin
            bad++;
            $display("FAIL load_pulse got st=%0d ld=%b val=%h want 1 1 10",
                     state, dp.pc_load, dp.pc_load_val);
        end
        tick(1);
        total++;
        if (state !== 3'd0 || dp.pc_load !== 1'b0 || cycle_cnt !== 4'd0
            || pc !== 8'h10) begin
            bad++;
            $display("FAIL load_end got st=%0d ld=%b cnt=%0d pc=%h want 0 0 0 10",
                     state, dp.pc_load, cycle_cnt, pc);
        end
    endtask

    task automatic test_step;
        logic [3:0] pat;
        logic [2:0] mid;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick(1);
            pat[0] = dp.cpu_en;
            step = 1'b0;
            tick(1);
            pat[1] = dp.cpu_en;
            mid = state;
            tick(1);
            pat[2] = dp.cpu_en;
            tick(1);
            pat[3] = dp.cpu_en;
            total++;
            if (pat !== 4'b0010 || mid !== 3'd3 || state !== 3'd0) begin
                bad++;
                $display("FAIL step_%0d got pat=%b mid=%0d st=%0d want 0010 3 0",
                         i, pat, mid, state);
            end
        end
        total++;
        if (cycle_cnt !== 4'd3 || pc !== 8'h1C) begin
            bad++;
            $display("FAIL step_cnt got cnt=%0d pc=%h want 3 1c", cycle_cnt, pc);
        end
    endtask

    task automatic test_breakpoint;
        do_load(8'h00);
        bp_en = 1'b1;
        bp_addr = 8'h0C;
        run = 1'b1;
        tick(1);
        run = 0;
        tick(7);
        total++;
        if (state !== 3'd0 || bp_flag !== 1'b1 || pc !== 8'h0C || cycle_cnt !== 4'd3) begin
            bad++;
            $display("FAIL bp_stop got st=%0d bf=%b pc=%h cnt=%0d want 0 1 0c 3",
                     state, bp_flag, pc, cycle_cnt);
        end
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(4);
        total++;
        if (state !== 3'd2 || bp_flag !== 1'b0 || pc !== 8'h18 || cycle_cnt !== 4'd6) begin
            bad++;
            $display("FAIL bp_resume got st=%0d bf=%b pc=%h cnt=%0d want 2 0 18 6",
                     state, bp_flag, pc, cycle_cnt);
        end
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(1);
        total++;
        if (state !== 3'd0 || pc !== 8'h20 || cycle_cnt !== 4'd8) begin
            bad++;
            $display("FAIL bp_halt got st=%0d pc=%h cnt=%0d want 0 20 8",
                     state, pc, cycle_cnt);
        end
        bp_en = 1'b0;
        tick(2);
    endtask

    task automatic test_exception;
        do_load(8'h00);
        exc_at = 8'h08;
        exc_arm = 1'b1;
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(3);
        total++;
        if (dp.cpu_en !== 1'b0 || state !== 3'd2 || pc !== 8'h08) begin
            bad++;
            $display("FAIL exc_cyc got en=%b st=%0d pc=%h want 0 2 08",
                     dp.cpu_en, state, pc);
        end
        tick(1);
        total++;
        if (state !== 3'd4 || exc_flag !== 1'b1 || exc_pc !== 8'h08
            || cycle_cnt !== 4'd2) begin
            bad++;
            $display("FAIL exc_state got st=%0d ef=%b epc=%h cnt=%0d want 4 1 08 2",
                     state, exc_flag, exc_pc, cycle_cnt);
        end
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(3);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(3);
        total++;
        if (state !== 3'd4 || cycle_cnt !== 4'd2 || pc !== 8'h08 || exc_flag !== 1'b1) begin
            bad++;
            $display("FAIL exc_ignore got st=%0d cnt=%0d pc=%h ef=%b want 4 2 08 1",
                     state, cycle_cnt, pc, exc_flag);
        end
        exc_arm = 1'b0;
        do_load(8'h20);
        total++;
        if (state !== 3'd0 || exc_flag !== 1'b0 || exc_pc !== 8'h00
            || bp_flag !== 1'b0 || cycle_cnt !== 4'd0 || pc !== 8'h20) begin
            bad++;
            $display("FAIL exc_clear got st=%0d ef=%b epc=%h bf=%b cnt=%0d pc=%h want 0 0 00 0 0 20",
                     state, exc_flag, exc_pc, bp_flag, cycle_cnt, pc);
        end
    endtask

    task automatic test_halt_step;
        run = 1'b1;
        tick(3);
        halt = 1'b1;
        step = 1'b1;
        tick(1);
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL hs_lat got st=%0d want 2", state);
        end
        tick(1);
        total++;
        if (state !== 3'd0 || cycle_cnt !== 4'd3 || pc !== 8'h2C) begin
            bad++;
            $display("FAIL hs_stop got st=%0d cnt=%0d pc=%h want 0 3 2c",
                     state, cycle_cnt, pc);
        end
        halt = 1'b0;
        step = 1'b0;
        tick(6);
        total++;
        if (state !== 3'd0 || cycle_cnt !== 4'd3 || dp.cpu_en !== 1'b0) begin
            bad++;
            $display("FAIL hs_hold got st=%0d cnt=%0d en=%b want 0 3 0",
                     state, cycle_cnt, dp.cpu_en);
        end
        run = 1'b0;
        tick(2);
    endtask

    task automatic test_saturate_reset;
        do_load(8'h30);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(22);
        total++;
        if (cycle_cnt !== 4'd15 || state !== 3'd2 || dp.cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL sat got cnt=%0d st=%0d en=%b want 15 2 1",
                     cycle_cnt, state, dp.cpu_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || dp.cpu_en !== 1'b0 || dp.pc_load !== 1'b0
            || dp.pc_load_val !== 8'h00 || cycle_cnt !== 4'd0) begin
            bad++;
            $display("FAIL async_rst got st=%0d en=%b ld=%b val=%h cnt=%0d want 0 0 0 00 0",
                     state, dp.cpu_en, dp.pc_load, dp.pc_load_val, cycle_cnt);
        end
        tick(2);
        rst = 1'b0;
        tick(3);
        total++;
        if (state !== 3'd0 || dp.cpu_en !== 1'b0 || exc_flag !== 1'b0 || bp_flag !== 1'b0) begin
            bad++;
            $display("FAIL post_rst got st=%0d en=%b ef=%b bf=%b want 0 0 0 0",
                     state, dp.cpu_en, exc_flag, bp_flag);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        halt = 1'b0;
        load = 1'b0;
        pc_val = 8'h00;
        bp_en = 1'b0;
        bp_addr = 8'h00;
        exc_arm = 1'b0;
        exc_at = 8'h00;
        pc = 8'h00;
        test_reset();
        test_load();
        test_step();
        test_breakpoint();
        test_exception();
        test_halt_step();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
